stopwatch_disp_src: RTL and testbench
=====================================

Name: stopwatch_disp_src

Overview:
- Up/down stopwatch (MM.SS.hh, 10 ms resolution) that generates the display payload for the 6-digit dynamic seg/595 driver.
- Sits directly upstream of that driver: data, dp, sign and seg_en are its outputs.
- Driven by debounced single-cycle key pulses.
- Supports count-up, and count-down from a preset with signed overtime after zero.

Parameters:
- CNT_TICK_MAX, 20'd499_999: sys_clk cycles per 10 ms tick minus 1 (50 MHz).
- PRESET_MM, 7'd1: count-down start minutes (0..99).
- PRESET_SS, 6'd0: count-down start seconds (0..59).
- BLINK_TICKS, 7'd50: ticks per seg_en half-period while paused.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- key_run  in  1  1-cycle pulse, debounced upstream: start/pause/resume.
- key_clr  in  1  1-cycle pulse: clear/reload.
- mode     in  1  0 = count up, 1 = count down; sampled only on reset/clear.
- data     out 20 binary value mm*10000+ss*100+hh, to display driver.
- dp       out 6  decimal-point enables, bit0 = rightmost digit.
- sign     out 1  1 = negative (overtime) value.
- seg_en   out 1  display enable.
- running  out 1  1 while in RUN.

Behaviour:
- Single clock sys_clk; sys_rst synchronous active-high; every register resets on sys_rst.
- Reset values:
  - data=0, dp=0, sign=0, seg_en=0, running=0.
  - State IDLE, dir=0 (up), neg=0, hh=ss=mm=0, tick_cnt=0, blink_cnt=0.
- First cycle after reset: dp=6'b010100 (points after SS and MM digits, constant thereafter) and seg_en=1.
  - Reset does not sample mode; dir stays up until the first clear.
- Tick generator:
  - tick_cnt counts 0..CNT_TICK_MAX and wraps.
  - tick is asserted for one cycle when tick_cnt==CNT_TICK_MAX.
  - tick_cnt is cleared on key_clr and on the IDLE->RUN transition.
- States: IDLE, RUN, PAUSE, SAT.
  - IDLE + key_run -> RUN.
  - RUN + key_run -> PAUSE.
  - PAUSE + key_run -> RUN.
  - RUN + saturation -> SAT.
  - SAT ignores key_run.
  - key_clr in any state -> IDLE.
  - key_clr on the same cycle as key_run: clear wins, run is ignored.
- Clear:
  - dir<=mode, neg<=0.
  - Counters load 00:00.00 if mode=0, else PRESET_MM:PRESET_SS.00.
  - Clear takes effect the next cycle.
- Counting happens only on tick in RUN. Magnitude steps up if (dir==0 or neg==1), else down.
- Up step:
  - hh 0..99 carries to ss; ss 0..59 carries to mm.
  - At 99:59.99 the next tick does not change the value; state goes to SAT and running=0.
- Down step:
  - Borrow chain is hh 0 -> 99, ss 0 -> 59, mm decrement.
  - A tick at 00:00.00 with neg=0 sets neg=1 and value=00:00.01; counting then continues upward.
  - Down mode with preset 00:00 and key_run: the first tick goes negative.
- Output latency:
  - data is registered from the counters: counter update in cycle N appears on data in cycle N+1.
  - sign follows neg with the same 1-cycle latency.
  - Max data value is 995999, which fits in 20 bits.
  - Constant-multiply is shift-add; no multiplier primitive is required.
- seg_en:
  - 1 in IDLE, RUN and SAT.
  - In PAUSE it toggles every BLINK_TICKS ticks, starting at 1; blink_cnt is cleared on PAUSE entry.
  - Leaving PAUSE forces seg_en=1 on the next cycle.
- running = (state==RUN), registered.
- Reset mid-count: all state returns to reset values next cycle; no partial output.

Test Plan:
- Up count (CNT_TICK_MAX=4, BLINK_TICKS=2):
  - reset, key_clr with mode=0, key_run, run 5*101 cycles -> data=101 (00:01.01), sign=0, running=1.
- Carry:
  - Force-load 00:59.99 via a down-mode preset sequence, or run 6000 ticks -> data steps 5999 -> 10000 exactly one cycle after the tick.
- Count-down into overtime (PRESET_MM=0, PRESET_SS=1):
  - clr mode=1, run 100 ticks -> data=0, sign=0.
  - Next tick -> data=1, sign=1.
  - 99 more ticks -> data=100, sign=1.
- Pause blink:
  - RUN then key_run -> running=0, data frozen, seg_en 1,0,1 toggling every 2 ticks.
  - key_run again -> seg_en=1 next cycle, counting resumes.
- Simultaneous keys:
  - key_run and key_clr on the same cycle during RUN -> state IDLE, data reloads (0 or preset), running=0.
- Saturation:
  - Up mode reaching 99:59.99 -> data=995999 held, running=0.
  - Further key_run ignored; key_clr recovers to data=0.

Source files
------------

// File: rtl/stopwatch_disp_src.sv
// Up/down MM.SS.hh stopwatch (10 ms resolution) producing data/dp/sign/seg_en
// for the downstream 6-digit seg/595 display driver.
//
// state | meaning
// IDLE  | cleared or reloaded, waiting for key_run
// RUN   | counting on every 10 ms tick
// PAUSE | value frozen, display blinking
// SAT   | up count reached 99:59.99, value held until key_clr

module stopwatch_disp_src #(
    parameter logic [19:0] CNT_TICK_MAX = 20'd499_999,
    parameter logic [6:0]  PRESET_MM    = 7'd1,
    parameter logic [5:0]  PRESET_SS    = 6'd0,
    parameter logic [6:0]  BLINK_TICKS  = 7'd50
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        key_run,
    input  logic        key_clr,
    input  logic        mode,
    output logic [19:0] data,
    output logic [5:0]  dp,
    output logic        sign,
    output logic        seg_en,
    output logic        running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        SAT   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] tick_cnt_q, tick_cnt_d;
    logic        dir_q, dir_d;
    logic        neg_q, neg_d;
    logic [6:0]  hh_q, hh_d;
    logic [5:0]  ss_q, ss_d;
    logic [6:0]  mm_q, mm_d;
    logic [6:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_on_q, blink_on_d;
    logic [19:0] data_q, data_d;
    logic [5:0]  dp_q, dp_d;
    logic        sign_q, sign_d;
    logic        seg_en_q, seg_en_d;
    logic        running_q, running_d;

    logic tick;
    logic step_up;
    logic at_max;
    logic at_zero;

    // x*100 = x*64 + x*32 + x*4
    function automatic logic [19:0] mul100(input logic [19:0] x);
        return (x << 6) + (x << 5) + (x << 2);
    endfunction

    assign tick    = (tick_cnt_q == CNT_TICK_MAX);
    assign step_up = !dir_q || neg_q;
    assign at_max  = (mm_q == 7'd99) && (ss_q == 6'd59) && (hh_q == 7'd99);
    assign at_zero = (mm_q == 7'd0) && (ss_q == 6'd0) && (hh_q == 7'd0);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            dir_q       <= 1'b0;
            neg_q       <= 1'b0;
            hh_q        <= '0;
            ss_q        <= '0;
            mm_q        <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
            data_q      <= '0;
            dp_q        <= '0;
            sign_q      <= 1'b0;
            seg_en_q    <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            dir_q       <= dir_d;
            neg_q       <= neg_d;
            hh_q        <= hh_d;
            ss_q        <= ss_d;
            mm_q        <= mm_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            data_q      <= data_d;
            dp_q        <= dp_d;
            sign_q      <= sign_d;
            seg_en_q    <= seg_en_d;
            running_q   <= running_d;
        end
    end

    // Clear beats every other event; saturation beats a coincident key_run.
    always_comb begin
        state_d = state_q;
        if (key_clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (key_run) state_d = RUN;
                RUN: begin
                    if (tick && step_up && at_max) state_d = SAT;
                    else if (key_run)              state_d = PAUSE;
                end
                PAUSE:   if (key_run) state_d = RUN;
                SAT:     state_d = SAT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tick_cnt_d  = tick ? 20'd0 : tick_cnt_q + 20'd1;
        dir_d       = dir_q;
        neg_d       = neg_q;
        hh_d        = hh_q;
        ss_d        = ss_q;
        mm_d        = mm_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;

        if (key_clr || (state_q == IDLE && key_run)) begin
            tick_cnt_d = '0;
        end

        if (key_clr) begin
            dir_d = mode;
            neg_d = 1'b0;
            hh_d  = '0;
            ss_d  = mode ? PRESET_SS : 6'd0;
            mm_d  = mode ? PRESET_MM : 7'd0;
        end else if (state_q == RUN && tick) begin
            if (step_up) begin
                if (!at_max) begin
                    if (hh_q == 7'd99) begin
                        hh_d = '0;
                        if (ss_q == 6'd59) begin
                            ss_d = '0;
                            mm_d = mm_q + 7'd1;
                        end else begin
                            ss_d = ss_q + 6'd1;
                        end
                    end else begin
                        hh_d = hh_q + 7'd1;
                    end
                end
            end else if (at_zero) begin
                // Zero crossing in count-down: flip to overtime and count up.
                neg_d = 1'b1;
                hh_d  = 7'd1;
            end else begin
                if (hh_q == 7'd0) begin
                    hh_d = 7'd99;
                    if (ss_q == 6'd0) begin
                        ss_d = 6'd59;
                        mm_d = mm_q - 7'd1;
                    end else begin
                        ss_d = ss_q - 6'd1;
                    end
                end else begin
                    hh_d = hh_q - 7'd1;
                end
            end
        end

        if (state_q != PAUSE) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_TICKS - 7'd1) begin
                blink_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 7'd1;
            end
        end
    end

    always_comb begin
        data_d    = mul100(mul100({13'd0, mm_q}) + {14'd0, ss_q}) + {13'd0, hh_q};
        dp_d      = 6'b010100;
        sign_d    = neg_q;
        seg_en_d  = (state_d == PAUSE) ? blink_on_d : 1'b1;
        running_d = (state_d == RUN);
    end

    assign data    = data_q;
    assign dp      = dp_q;
    assign sign    = sign_q;
    assign seg_en  = seg_en_q;
    assign running = running_q;

endmodule

// File: tb/tb_stopwatch_disp_src.sv
// Bench for stopwatch_disp_src: hand-derived vector table, forced-load corner
// sequences and a randomized run against a hundredths-of-a-second model.

module tb_stopwatch_disp_src;

    localparam logic [19:0] CNT = 20'd4;
    localparam logic [6:0]  PMM = 7'd0;
    localparam logic [5:0]  PSS = 6'd1;
    localparam logic [6:0]  BLK = 7'd2;
    localparam int MAG_MAX = 599999;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_SAT = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        key_run = 1'b0;
    logic        key_clr = 1'b0;
    logic        mode    = 1'b0;
    logic [19:0] data;
    logic [5:0]  dp;
    logic        sign;
    logic        seg_en;
    logic        running;

    int checks = 0;
    int errors = 0;

    int          m_st, m_ph, m_mag, m_bcnt;
    logic        m_neg, m_dir, m_bon;
    logic [19:0] e_data;
    logic        e_sign, e_seg, e_run;
    logic [5:0]  e_dp;

    typedef struct {
        logic        run;
        logic        clr;
        logic        md;
        int          n;
        logic [19:0] data;
        logic        sign;
        logic        running;
        logic        seg_en;
    } vec_t;

    vec_t        vtab [23];
    logic        found;
    logic [19:0] prev;

    stopwatch_disp_src #(
        .CNT_TICK_MAX (CNT),
        .PRESET_MM    (PMM),
        .PRESET_SS    (PSS),
        .BLINK_TICKS  (BLK)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_run (key_run),
        .key_clr (key_clr),
        .mode    (mode),
        .data    (data),
        .dp      (dp),
        .sign    (sign),
        .seg_en  (seg_en),
        .running (running)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int fmt(input int mag);
        return (mag / 6000) * 10000 + ((mag % 6000) / 100) * 100 + mag % 100;
    endfunction

    // Model: value held as total hundredths; outputs reflect the pre-edge value.
    task automatic model_step(input logic r, input logic c, input logic md, input logic rs);
        int   nst;
        logic tk, up;
        if (rs) begin
            m_st = S_IDLE; m_ph = 0; m_mag = 0; m_bcnt = 0;
            m_neg = 1'b0; m_dir = 1'b0; m_bon = 1'b0;
            e_data = '0; e_sign = 1'b0; e_seg = 1'b0; e_run = 1'b0; e_dp = '0;
            return;
        end
        tk  = (m_ph == int'(CNT));
        up  = !m_dir || m_neg;
        nst = m_st;
        if (c) nst = S_IDLE;
        else begin
            case (m_st)
                S_IDLE:  if (r) nst = S_RUN;
                S_RUN: begin
                    if (tk && up && m_mag == MAG_MAX) nst = S_SAT;
                    else if (r)                       nst = S_PAUSE;
                end
                S_PAUSE: if (r) nst = S_RUN;
                default: ;
            endcase
        end
        e_data = 20'(fmt(m_mag));
        e_sign = m_neg;
        e_dp   = 6'b010100;
        if (c) begin
            m_dir = md;
            m_neg = 1'b0;
            m_mag = md ? int'(PMM) * 6000 + int'(PSS) * 100 : 0;
        end else if (m_st == S_RUN && tk) begin
            if (up) begin
                if (m_mag != MAG_MAX) m_mag++;
            end else if (m_mag == 0) begin
                m_neg = 1'b1;
                m_mag = 1;
            end else begin
                m_mag--;
            end
        end
        if (m_st != S_PAUSE) begin
            m_bcnt = 0;
            m_bon  = 1'b1;
        end else if (tk) begin
            m_bcnt++;
            if (m_bcnt == int'(BLK)) begin
                m_bcnt = 0;
                m_bon  = !m_bon;
            end
        end
        if (c || (m_st == S_IDLE && r)) m_ph = 0;
        else                            m_ph = tk ? 0 : m_ph + 1;
        m_st  = nst;
        e_run = (m_st == S_RUN);
        e_seg = (m_st == S_PAUSE) ? m_bon : 1'b1;
    endtask

    task automatic clk1(input logic r, input logic c, input logic md, input logic rs);
        key_run = r;
        key_clr = c;
        mode    = md;
        sys_rst = rs;
        @(posedge sys_clk);
        #1;
        model_step(r, c, md, rs);
        key_run = 1'b0;
        key_clr = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".data"},    data,    e_data);
        chk({tag, ".sign"},    sign,    e_sign);
        chk({tag, ".seg_en"},  seg_en,  e_seg);
        chk({tag, ".running"}, running, e_run);
        chk({tag, ".dp"},      dp,      e_dp);
    endtask

    initial begin
        //             run   clr   md    n    data      sign  run   seg
        vtab[0]  = '{1'b0, 1'b0, 1'b0,   1, 20'd0,   1'b0, 1'b0, 1'b1};
        vtab[1]  = '{1'b0, 1'b1, 1'b0,   1, 20'd0,   1'b0, 1'b0, 1'b1};
        vtab[2]  = '{1'b1, 1'b0, 1'b0, 506, 20'd100, 1'b0, 1'b1, 1'b1};
        vtab[3]  = '{1'b0, 1'b0, 1'b0,   1, 20'd101, 1'b0, 1'b1, 1'b1};
        vtab[4]  = '{1'b1, 1'b0, 1'b0,   1, 20'd101, 1'b0, 1'b0, 1'b1};
        vtab[5]  = '{1'b0, 1'b0, 1'b0,   7, 20'd101, 1'b0, 1'b0, 1'b1};
        vtab[6]  = '{1'b0, 1'b0, 1'b0,   1, 20'd101, 1'b0, 1'b0, 1'b0};
        vtab[7]  = '{1'b0, 1'b0, 1'b0,   9, 20'd101, 1'b0, 1'b0, 1'b0};
        vtab[8]  = '{1'b0, 1'b0, 1'b0,   1, 20'd101, 1'b0, 1'b0, 1'b1};
        vtab[9]  = '{1'b0, 1'b0, 1'b0,   9, 20'd101, 1'b0, 1'b0, 1'b1};
        vtab[10] = '{1'b0, 1'b0, 1'b0,   1, 20'd101, 1'b0, 1'b0, 1'b0};
        vtab[11] = '{1'b1, 1'b0, 1'b0,   1, 20'd101, 1'b0, 1'b1, 1'b1};
        vtab[12] = '{1'b0, 1'b0, 1'b0,   4, 20'd101, 1'b0, 1'b1, 1'b1};
        vtab[13] = '{1'b0, 1'b0, 1'b0,   1, 20'd102, 1'b0, 1'b1, 1'b1};
        vtab[14] = '{1'b1, 1'b1, 1'b0,   1, 20'd102, 1'b0, 1'b0, 1'b1};
        vtab[15] = '{1'b0, 1'b0, 1'b0,   1, 20'd0,   1'b0, 1'b0, 1'b1};
        vtab[16] = '{1'b0, 1'b0, 1'b0,  10, 20'd0,   1'b0, 1'b0, 1'b1};
        vtab[17] = '{1'b0, 1'b1, 1'b1,   1, 20'd0,   1'b0, 1'b0, 1'b1};
        vtab[18] = '{1'b0, 1'b0, 1'b1,   1, 20'd100, 1'b0, 1'b0, 1'b1};
        vtab[19] = '{1'b1, 1'b0, 1'b1,   1, 20'd100, 1'b0, 1'b1, 1'b1};
        vtab[20] = '{1'b0, 1'b0, 1'b1, 501, 20'd0,   1'b0, 1'b1, 1'b1};
        vtab[21] = '{1'b0, 1'b0, 1'b1,   5, 20'd1,   1'b1, 1'b1, 1'b1};
        vtab[22] = '{1'b0, 1'b0, 1'b1, 495, 20'd100, 1'b1, 1'b1, 1'b1};

        clk1(1'b0, 1'b0, 1'b0, 1'b1);
        clk1(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst.data", data, 0);
        chk("rst.dp", dp, 0);
        chk("rst.sign", sign, 0);
        chk("rst.seg_en", seg_en, 0);
        chk("rst.running", running, 0);

        for (int i = 0; i < 23; i++) begin
            for (int k = 0; k < vtab[i].n; k++) begin
                clk1((k == 0) ? vtab[i].run : 1'b0, (k == 0) ? vtab[i].clr : 1'b0,
                     vtab[i].md, 1'b0);
            end
            chk($sformatf("vec%0d.data", i),    data,    vtab[i].data);
            chk($sformatf("vec%0d.sign", i),    sign,    vtab[i].sign);
            chk($sformatf("vec%0d.running", i), running, vtab[i].running);
            chk($sformatf("vec%0d.seg_en", i),  seg_en,  vtab[i].seg_en);
            chk($sformatf("vec%0d.dp", i),      dp,      6'b010100);
        end

        // Minute carry: load 00:59.97 while paused, then resume.
        clk1(1'b0, 1'b1, 1'b0, 1'b0); check_model("carry_clr");
        clk1(1'b1, 1'b0, 1'b0, 1'b0); check_model("carry_run");
        clk1(1'b1, 1'b0, 1'b0, 1'b0); check_model("carry_pause");
        force dut.mm_q = 7'd0;
        force dut.ss_q = 6'd59;
        force dut.hh_q = 7'd97;
        m_mag = 5997;
        clk1(1'b0, 1'b0, 1'b0, 1'b0); check_model("carry_load");
        release dut.mm_q;
        release dut.ss_q;
        release dut.hh_q;
        clk1(1'b1, 1'b0, 1'b0, 1'b0); check_model("carry_resume");
        found = 1'b0;
        prev  = data;
        for (int i = 0; i < 100 && !found; i++) begin
            clk1(1'b0, 1'b0, 1'b0, 1'b0);
            check_model("carry");
            if (data == 20'd10000) found = 1'b1;
            else                   prev  = data;
        end
        chk("carry_seen", found, 1);
        chk("carry_prev", prev, 5999);

        // Saturation: load 99:59.97, run into the ceiling.
        clk1(1'b1, 1'b0, 1'b0, 1'b0); check_model("sat_pause");
        force dut.mm_q = 7'd99;
        force dut.ss_q = 6'd59;
        force dut.hh_q = 7'd97;
        m_mag = 599997;
        clk1(1'b0, 1'b0, 1'b0, 1'b0); check_model("sat_load");
        release dut.mm_q;
        release dut.ss_q;
        release dut.hh_q;
        clk1(1'b1, 1'b0, 1'b0, 1'b0); check_model("sat_resume");
        for (int i = 0; i < 100 && m_st != S_SAT; i++) begin
            clk1(1'b0, 1'b0, 1'b0, 1'b0);
            check_model("sat_run");
        end
        for (int i = 0; i < 12; i++) begin
            clk1(1'b0, 1'b0, 1'b0, 1'b0);
            check_model("sat_hold");
        end
        chk("sat.data", data, 995999);
        chk("sat.running", running, 0);
        for (int i = 0; i < 3; i++) begin
            clk1(1'b1, 1'b0, 1'b0, 1'b0);
            check_model("sat_key");
        end
        chk("sat_key.data", data, 995999);
        chk("sat_key.running", running, 0);
        clk1(1'b0, 1'b1, 1'b0, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_clr.data", data, 0);
        chk("sat_clr.seg_en", seg_en, 1);
        chk("sat_clr.running", running, 0);

        // Reset in the middle of a count.
        clk1(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) clk1(1'b0, 1'b0, 1'b0, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b1);
        chk("midrst.data", data, 0);
        chk("midrst.seg_en", seg_en, 0);
        chk("midrst.running", running, 0);
        chk("midrst.dp", dp, 0);
        clk1(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst1.data", data, 0);
        chk("midrst1.seg_en", seg_en, 1);
        chk("midrst1.dp", dp, 6'b010100);

        // Randomized traffic; second half uses rare keys to reach long runs.
        for (int i = 0; i < 4000; i++) begin
            logic r, c, md, rs;
            if (i < 2000) begin
                r = ($urandom_range(0, 19) == 0);
                c = ($urandom_range(0, 59) == 0);
            end else begin
                r = ($urandom_range(0, 199) == 0);
                c = ($urandom_range(0, 799) == 0);
            end
            md = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 999) == 0);
            clk1(r, c, md, rs);
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
